// File: rtl/ddr_tx_gearbox.sv
// Word-to-beat gearbox feeding the per-lane DDR output cells: a small FIFO,
// then a serializer that sends one LANES-rise/LANES-fall beat per clk, LSB beat first.
module ddr_tx_gearbox #(
  parameter int                 LANES      = 4,
  parameter int                 WORD_W     = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [LANES-1:0]   IDLE_R     = {LANES{1'b0}},
  parameter logic [LANES-1:0]   IDLE_F     = {LANES{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              clr_underrun,
  output logic [LANES-1:0]  data_r,
  output logic [LANES-1:0]  data_f,
  output logic              tx_active,
  output logic              tx_last,
  output logic              underrun
);

  localparam int BEATS  = WORD_W / (2 * LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [AW:0]       DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;

  generate
    if ((WORD_W % (2 * LANES)) != 0) begin : g_bad_word_w
      $error("ddr_tx_gearbox: WORD_W must be a multiple of 2*LANES");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ddr_tx_gearbox: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // FIFO: register-based so the head word can be sliced on the same edge it is popped
  logic [WORD_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              wr_en, pop, fifo_empty;
  logic [WORD_W-1:0] head_word;
  logic              head_last;

  assign s_ready    = (count_reg < DEPTH_C);
  assign wr_en      = s_valid && s_ready;
  assign fifo_empty = (count_reg == '0);
  assign {head_last, head_word} = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {s_last, s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + (AW + 1)'(1);
      else if (pop && !wr_en) count_reg <= count_reg - (AW + 1)'(1);
    end
  end

  // Serializer
  logic [1:0]          state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg;
  logic [WORD_W-1:0]   cur_word_reg;
  logic                cur_last_reg;
  logic [LANES-1:0]    data_r_reg, data_f_reg;
  logic                tx_active_reg, tx_last_reg, underrun_reg;

  logic                drive, set_ur, src_last;
  logic [WORD_W-1:0]   src_word;
  logic [BEAT_W-1:0]   src_idx;
  logic [2*LANES-1:0]  beat_bits;
  logic                beat_is_last;

  always_comb begin
    pop        = 1'b0;
    drive      = 1'b0;
    set_ur     = 1'b0;
    state_next = state_reg;
    src_word   = cur_word_reg;
    src_idx    = beat_reg + BEAT_W'(1);
    src_last   = cur_last_reg;
    case (state_reg)
      ST_IDLE, ST_STALL: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (beat_reg != LAST_BEAT) begin
          drive = 1'b1;
        end else if (cur_last_reg) begin
          state_next = ST_IDLE;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          // word boundary inside a packet with nothing buffered
          state_next = ST_STALL;
          set_ur     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (pop) begin
      drive    = 1'b1;
      src_word = head_word;
      src_idx  = '0;
      src_last = head_last;
    end
    beat_bits    = src_word[int'(src_idx) * 2 * LANES +: 2 * LANES];
    beat_is_last = src_last && (src_idx == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      cur_word_reg  <= '0;
      cur_last_reg  <= 1'b0;
      data_r_reg    <= IDLE_R;
      data_f_reg    <= IDLE_F;
      tx_active_reg <= 1'b0;
      tx_last_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        cur_word_reg <= head_word;
        cur_last_reg <= head_last;
      end
      if (drive) begin
        beat_reg      <= src_idx;
        data_r_reg    <= beat_bits[LANES-1:0];
        data_f_reg    <= beat_bits[2*LANES-1:LANES];
        tx_active_reg <= 1'b1;
        tx_last_reg   <= beat_is_last;
      end else begin
        data_r_reg    <= IDLE_R;
        data_f_reg    <= IDLE_F;
        tx_active_reg <= 1'b0;
        tx_last_reg   <= 1'b0;
      end
      if (set_ur)            underrun_reg <= 1'b1;
      else if (clr_underrun) underrun_reg <= 1'b0;
    end
  end

  assign data_r    = data_r_reg;
  assign data_f    = data_f_reg;
  assign tx_active = tx_active_reg;
  assign tx_last   = tx_last_reg;
  assign underrun  = underrun_reg;

  a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && count_reg == DEPTH_C));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && fifo_empty));

endmodule
